// File: rtl/jtag_fifo_pkg.sv
// rtl/jtag_fifo_pkg.sv - shared state encoding and default parameters for the JTAG shift-out sequencer
package jtag_fifo_pkg;

    localparam int c_DEF_DATA_WIDTH     = 8;
    localparam int c_DEF_RD_DEPTH_WIDTH = 9;
    localparam int c_DEF_CNT_WIDTH      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_PAD  = 2'd3
    } jtag_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jtag_shift_out_seq_if.sv
// rtl/jtag_shift_out_seq_if.sv - FIFO read-side bundle between the sequencer and the read FIFO
// Signals: fifo_r_en (read strobe), fifo_rempty (empty flag),
//          fifo_rd_water_level (fill level), fifo_rdata (RAM data, one cycle after fifo_r_en).
// master: sequencer side; slave: FIFO side.
interface jtag_shift_out_seq_if
    import jtag_fifo_pkg::*;
#(
    parameter int c_DATA_WIDTH     = c_DEF_DATA_WIDTH,
    parameter int c_RD_DEPTH_WIDTH = c_DEF_RD_DEPTH_WIDTH
);
    logic                      fifo_r_en;
    logic                      fifo_rempty;
    logic [c_RD_DEPTH_WIDTH:0] fifo_rd_water_level;
    logic [c_DATA_WIDTH-1:0]   fifo_rdata;

    modport master (
        output fifo_r_en,
        input  fifo_rempty,
        input  fifo_rd_water_level,
        input  fifo_rdata
    );

    modport slave (
        input  fifo_r_en,
        output fifo_rempty,
        output fifo_rd_water_level,
        output fifo_rdata
    );
endinterface

// File: rtl/jtag_shift_out_sreg.sv
// rtl/jtag_shift_out_sreg.sv - loadable LSB-first shift register with a shifted-bit counter
// Ports: clk/rst_n (async active-low), load/load_val (load wins over shift, clears counter),
//        shift (shift right, zero fill, count up), sout (bit 0), bit_cnt (bits shifted since load).
module jtag_shift_out_sreg #(
    parameter int c_WIDTH     = 8,
    parameter int c_CNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [c_WIDTH-1:0]     load_val,
    input  logic                   shift,
    output logic                   sout,
    output logic [c_CNT_WIDTH-1:0] bit_cnt
);
    logic [c_WIDTH-1:0]     data_q, data_d;
    logic [c_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            data_d    = load_val;
            bit_cnt_d = '0;
        end else if (shift) begin
            data_d    = {1'b0, data_q[c_WIDTH-1:1]};
            // Free-running wrap is harmless: only HDR/DATA compare against it.
            bit_cnt_d = bit_cnt_q + c_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign sout    = data_q[0];
    assign bit_cnt = bit_cnt_q;
endmodule

// File: rtl/jtag_shift_out_seq.sv
// rtl/jtag_shift_out_seq.sv - streams a count header then FIFO words out of TDO, LSB first
// Ports: rclk, rrst_n (async active-low), capture_dr/shift_dr/update_dr (TAP),
//        tdo (serial out), busy (not IDLE), underrun (sticky), fifo (FIFO read bundle, master).
module jtag_shift_out_seq
    import jtag_fifo_pkg::*;
#(
    parameter int c_DATA_WIDTH     = c_DEF_DATA_WIDTH,
    parameter int c_RD_DEPTH_WIDTH = c_DEF_RD_DEPTH_WIDTH,
    parameter int c_CNT_WIDTH      = c_DEF_CNT_WIDTH
) (
    input  logic rclk,
    input  logic rrst_n,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_dr,
    output logic tdo,
    output logic busy,
    output logic underrun,
    jtag_shift_out_seq_if.master fifo
);
    localparam int SW   = max_int(c_DATA_WIDTH, c_CNT_WIDTH);
    localparam int BCW  = $clog2(SW) + 1;
    localparam int CMPW = max_int(c_RD_DEPTH_WIDTH + 1, c_CNT_WIDTH);
    localparam logic [c_CNT_WIDTH-1:0] CNT_MAX = '1;

    jtag_state_e             state_q, state_d;
    logic [c_CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [c_DATA_WIDTH-1:0] hold_q, hold_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    underrun_q, underrun_d;

    logic [CMPW-1:0]         wl_ext;
    logic [c_CNT_WIDTH-1:0]  burst_cnt;
    logic                    shift_en, hdr_last, data_last, rd_need;
    logic                    sreg_load, sreg_out;
    logic [SW-1:0]           sreg_val;
    logic [BCW-1:0]          bit_cnt;

    assign wl_ext    = CMPW'(fifo.fifo_rd_water_level);
    assign burst_cnt = (wl_ext > CMPW'(CNT_MAX)) ? CNT_MAX : c_CNT_WIDTH'(wl_ext);
    assign shift_en  = shift_dr && (state_q != ST_IDLE);
    assign hdr_last  = shift_en && (state_q == ST_HDR)  && (bit_cnt == BCW'(c_CNT_WIDTH - 1));
    assign data_last = shift_en && (state_q == ST_DATA) && (bit_cnt == BCW'(c_DATA_WIDTH - 1));

    // remaining counts words still to be moved into the shift register after the
    // one currently shifting. The next word is prefetched at the moment the current
    // one is loaded, so hold_q is always ready a full word-time ahead.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        underrun_d  = underrun_q;
        rd_need     = 1'b0;
        sreg_load   = 1'b0;
        sreg_val    = '0;

        if (rd_pend_q) begin
            hold_d = fifo.fifo_rdata;
        end

        if (capture_dr) begin
            state_d     = ST_HDR;
            sreg_load   = 1'b1;
            sreg_val    = SW'(burst_cnt);
            remaining_d = burst_cnt;
            rd_need     = (burst_cnt != '0);
        end else if (update_dr) begin
            state_d = ST_IDLE;
        end else if (hdr_last || data_last) begin
            sreg_load = 1'b1;
            if (remaining_q != '0) begin
                state_d     = ST_DATA;
                sreg_val    = SW'(hold_q);
                remaining_d = remaining_q - c_CNT_WIDTH'(1);
                rd_need     = (remaining_d != '0);
            end else begin
                state_d = ST_PAD;
            end
        end

        // A starved read still advances the burst; the missing word becomes zeros.
        if (rd_need && fifo.fifo_rempty) begin
            hold_d     = '0;
            underrun_d = 1'b1;
        end
    end

    assign rd_pend_d = fifo.fifo_r_en;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            hold_q      <= '0;
            rd_pend_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            rd_pend_q   <= rd_pend_d;
            underrun_q  <= underrun_d;
        end
    end

    jtag_shift_out_sreg #(
        .c_WIDTH     (SW),
        .c_CNT_WIDTH (BCW)
    ) u_sreg (
        .clk      (rclk),
        .rst_n    (rrst_n),
        .load     (sreg_load),
        .load_val (sreg_val),
        .shift    (shift_en),
        .sout     (sreg_out),
        .bit_cnt  (bit_cnt)
    );

    // Gated by reset so the strobe drops in the same cycle reset asserts.
    assign fifo.fifo_r_en = rrst_n && rd_need && !fifo.fifo_rempty;
    assign tdo            = sreg_out && (state_q != ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign underrun       = underrun_q;
endmodule

// File: tb/tb_jtag_shift_out_seq.sv
// tb/tb_jtag_shift_out_seq.sv - directed self-checking bench for jtag_shift_out_seq
module tb_jtag_shift_out_seq;
    logic rclk = 1'b0;
    logic rrst_n, capture_dr, shift_dr, update_dr;
    logic tdo, busy, underrun;

    jtag_shift_out_seq_if #(.c_DATA_WIDTH(8), .c_RD_DEPTH_WIDTH(9)) fif ();

    jtag_shift_out_seq #(
        .c_DATA_WIDTH(8), .c_RD_DEPTH_WIDTH(9), .c_CNT_WIDTH(8)
    ) dut (
        .rclk(rclk), .rrst_n(rrst_n), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .tdo(tdo), .busy(busy), .underrun(underrun), .fifo(fif)
    );

    always #5 rclk = ~rclk;

    logic [7:0] mem [0:511];
    int   nwords = 0;
    int   rptr = 0;
    int   rd_count = 0;
    int   viol = 0;
    logic force_empty = 1'b0;
    logic fifo_clr = 1'b0;
    logic [9:0] wl = '0;

    assign fif.fifo_rempty         = force_empty || (rptr >= nwords);
    assign fif.fifo_rd_water_level = wl;

    always @(posedge rclk) begin
        if (fif.fifo_r_en && fif.fifo_rempty) viol <= viol + 1;
        if (fifo_clr) begin
            rptr <= 0;
        end else if (fif.fifo_r_en) begin
            fif.fifo_rdata <= mem[rptr];
            rptr           <= rptr + 1;
            rd_count       <= rd_count + 1;
        end
    end

    int tests = 0;
    int fails = 0;
    logic got[$];
    logic t;

    task automatic step(input logic cap, input logic sh, input logic upd);
        @(negedge rclk);
        capture_dr = cap; shift_dr = sh; update_dr = upd;
        #1 t = tdo;
    endtask

    task automatic shift_collect(input int n, input bit toggle);
        int k;
        k = 0;
        while (k < n) begin
            step(1'b0, 1'b1, 1'b0);
            got.push_back(t);
            k++;
            if (toggle) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] gbyte(input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = got[b*8+i];
        return r;
    endfunction

    task automatic load_fifo(input int n, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        mem[0] = w0; mem[1] = w1; mem[2] = w2;
        nwords = n;
        @(negedge rclk); fifo_clr = 1'b1;
        @(negedge rclk); fifo_clr = 1'b0;
    endtask

    task automatic test_reset();
        capture_dr = 0; shift_dr = 0; update_dr = 0; rrst_n = 0;
        repeat (3) @(negedge rclk);
        tests++; if (tdo !== 1'b0) begin fails++; $display("FAIL reset_tdo got %b exp 0", tdo); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (fif.fifo_r_en !== 1'b0) begin fails++; $display("FAIL reset_r_en got %b exp 0", fif.fifo_r_en); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b exp 0", underrun); end
        rrst_n = 1;
        @(negedge rclk);
    endtask

    task automatic test_basic();
        int c0;
        logic [7:0] exp [5];
        exp = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h00};
        load_fifo(3, 8'hA1, 8'hB2, 8'hC3);
        wl = 10'd3; c0 = rd_count; got.delete();
        step(1, 0, 0);
        shift_collect(40, 0);
        for (int b = 0; b < 5; b++) begin
            tests++;
            if (gbyte(b) !== exp[b]) begin fails++; $display("FAIL basic_byte%0d got %h exp %h", b, gbyte(b), exp[b]); end
        end
        tests++; if (rd_count - c0 != 3) begin fails++; $display("FAIL basic_reads got %0d exp 3", rd_count - c0); end
        step(0, 0, 1); step(0, 0, 0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_zero();
        int c0;
        load_fifo(0, 8'h00, 8'h00, 8'h00);
        wl = 10'd0; c0 = rd_count; got.delete();
        step(1, 0, 0);
        shift_collect(24, 0);
        tests++; if ({gbyte(2), gbyte(1), gbyte(0)} !== 24'h0) begin fails++; $display("FAIL zero_stream got %h exp 000000", {gbyte(2), gbyte(1), gbyte(0)}); end
        tests++; if (rd_count != c0) begin fails++; $display("FAIL zero_reads got %0d exp 0", rd_count - c0); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL zero_underrun got %b exp 0", underrun); end
        step(0, 0, 1);
    endtask

    task automatic test_max();
        int c0, bad;
        for (int i = 0; i < 300; i++) mem[i] = i[7:0];
        nwords = 300;
        @(negedge rclk); fifo_clr = 1'b1;
        @(negedge rclk); fifo_clr = 1'b0;
        wl = 10'd300; c0 = rd_count; got.delete(); bad = 0;
        step(1, 0, 0);
        shift_collect(8 + 255*8 + 8, 0);
        tests++; if (gbyte(0) !== 8'hFF) begin fails++; $display("FAIL max_header got %h exp ff", gbyte(0)); end
        for (int k = 0; k < 255; k++) if (gbyte(1 + k) !== k[7:0]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL max_words got %0d bad words exp 0", bad); end
        tests++; if (gbyte(256) !== 8'h00) begin fails++; $display("FAIL max_pad got %h exp 00", gbyte(256)); end
        tests++; if (rd_count - c0 != 255) begin fails++; $display("FAIL max_reads got %0d exp 255", rd_count - c0); end
        step(0, 0, 1);
    endtask

    task automatic test_toggle();
        int c0;
        logic [7:0] exp [4];
        exp = '{8'h02, 8'h5A, 8'h3C, 8'h00};
        load_fifo(2, 8'h5A, 8'h3C, 8'h00);
        wl = 10'd2; c0 = rd_count; got.delete();
        step(1, 0, 0);
        shift_collect(32, 1);
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (gbyte(b) !== exp[b]) begin fails++; $display("FAIL toggle_byte%0d got %h exp %h", b, gbyte(b), exp[b]); end
        end
        tests++; if (rd_count - c0 != 2) begin fails++; $display("FAIL toggle_reads got %0d exp 2", rd_count - c0); end
        step(0, 0, 1);
    endtask

    task automatic test_underrun();
        int c0;
        logic [7:0] exp [4];
        exp = '{8'h02, 8'h11, 8'h00, 8'h00};
        load_fifo(2, 8'h11, 8'h22, 8'h00);
        wl = 10'd2; c0 = rd_count; got.delete();
        step(1, 0, 0);
        step(0, 0, 0);
        force_empty = 1'b1;
        shift_collect(32, 0);
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (gbyte(b) !== exp[b]) begin fails++; $display("FAIL underrun_byte%0d got %h exp %h", b, gbyte(b), exp[b]); end
        end
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_flag got %b exp 1", underrun); end
        tests++; if (rd_count - c0 != 1) begin fails++; $display("FAIL underrun_reads got %0d exp 1", rd_count - c0); end
        force_empty = 1'b0;
        step(0, 0, 1); repeat (5) step(0, 0, 0);
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_sticky got %b exp 1", underrun); end
        tests++; if (viol != 0) begin fails++; $display("FAIL read_while_empty got %0d exp 0", viol); end
    endtask

    task automatic test_update_reset();
        int c0;
        load_fifo(2, 8'h77, 8'h88, 8'h00);
        wl = 10'd2; got.delete();
        step(1, 0, 0);
        shift_collect(12, 0);
        step(0, 0, 1); step(0, 0, 0);
        tests++; if (busy !== 1'b0 || t !== 1'b0) begin fails++; $display("FAIL update_idle got busy=%b tdo=%b exp 0 0", busy, t); end
        load_fifo(2, 8'h99, 8'hAA, 8'h00);
        wl = 10'd2; got.delete();
        step(1, 0, 0);
        shift_collect(16, 0);
        tests++; if (gbyte(0) !== 8'h02) begin fails++; $display("FAIL update_new_header got %h exp 02", gbyte(0)); end
        tests++; if (gbyte(1) !== 8'h99) begin fails++; $display("FAIL update_new_word got %h exp 99", gbyte(1)); end
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        rrst_n = 1'b0;
        #1;
        tests++; if (tdo !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midburst_reset got tdo=%b busy=%b exp 0 0", tdo, busy); end
        tests++; if (fif.fifo_r_en !== 1'b0 || underrun !== 1'b0) begin fails++; $display("FAIL midburst_reset_flags got r_en=%b underrun=%b exp 0 0", fif.fifo_r_en, underrun); end
        c0 = rd_count;
        repeat (4) step(0, 1, 0);
        tests++; if (rd_count != c0) begin fails++; $display("FAIL reset_no_reads got %0d exp 0", rd_count - c0); end
        rrst_n = 1'b1;
        step(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_toggle();
        test_underrun();
        test_update_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
